// File: rtl/npu_axi_pkg.sv
// rtl/npu_axi_pkg.sv - shared AXI write-path types and constants
package npu_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AW    = 2'd1,
    ST_WDATA = 2'd2
  } wr_state_e;

  localparam int SRC_W    = 2;
  localparam int CREDIT_W = 4;

  // Source tag value that maps to no requester; B responses carrying it are sunk.
  localparam logic [SRC_W-1:0] SRC_INVALID = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter3.sv
// rtl/rr_arbiter3.sv - combinational 3-way round-robin grant starting at rr_ptr
module rr_arbiter3
  import npu_axi_pkg::*;
(
  input  logic [2:0]       req,
  input  logic [SRC_W-1:0] rr_ptr,
  output logic             grant_valid,
  output logic [SRC_W-1:0] grant_idx
);

  logic [2:0] cand;

  // Walk from the farthest candidate back to rr_ptr so the nearest requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 2; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (req[cand[1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[1:0];
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter_3x1.sv
// rtl/axi_wr_arbiter_3x1.sv - three-requester AXI write arbiter with credit-limited issue
module axi_wr_arbiter_3x1
  import npu_axi_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int S_ID_WIDTH      = 8,
  parameter int M_ID_WIDTH      = S_ID_WIDTH + 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [3*S_ID_WIDTH-1:0] s_axi_awid,
  input  logic [3*ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [3*8-1:0]          s_axi_awlen,
  input  logic [3*3-1:0]          s_axi_awsize,
  input  logic [3*2-1:0]          s_axi_awburst,
  input  logic [2:0]              s_axi_awvalid,
  output logic [2:0]              s_axi_awready,
  input  logic [3*DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [3*STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic [2:0]              s_axi_wlast,
  input  logic [2:0]              s_axi_wvalid,
  output logic [2:0]              s_axi_wready,
  output logic [3*S_ID_WIDTH-1:0] s_axi_bid,
  output logic [3*2-1:0]          s_axi_bresp,
  output logic [2:0]              s_axi_bvalid,
  input  logic [2:0]              s_axi_bready,

  output logic [M_ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [STRB_WIDTH-1:0]   m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [M_ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam logic [CREDIT_W-1:0] MAX_CRED = CREDIT_W'(MAX_OUTSTANDING);

  wr_state_e           state, state_nxt;
  logic [SRC_W-1:0]    rr_ptr;
  logic [SRC_W-1:0]    cur_src;
  logic [CREDIT_W-1:0] credits;
  logic                grant_valid;
  logic [SRC_W-1:0]    grant_idx;
  logic                can_grant;
  logic                aw_hs;
  logic                b_hs;
  logic                w_last_hs;
  logic [SRC_W-1:0]    b_dst;

  rr_arbiter3 u_rr (
    .req         (s_axi_awvalid),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign can_grant     = !rst && (state == ST_IDLE) && grant_valid && (credits < MAX_CRED);
  assign m_axi_awvalid = (state == ST_AW);
  assign aw_hs         = m_axi_awvalid && m_axi_awready;
  assign w_last_hs     = m_axi_wvalid && m_axi_wready && m_axi_wlast;
  assign b_hs          = m_axi_bvalid && m_axi_bready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    s_axi_awready = '0;
    case (state)
      ST_IDLE: begin
        if (can_grant) begin
          s_axi_awready[grant_idx] = 1'b1;
          state_nxt                = ST_AW;
        end
      end
      ST_AW:    if (m_axi_awready) state_nxt = ST_WDATA;
      ST_WDATA: if (w_last_hs) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // AW fields are captured at grant so the requester is free the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr        <= '0;
      cur_src       <= '0;
      m_axi_awid    <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      m_axi_awsize  <= '0;
      m_axi_awburst <= '0;
    end else if (can_grant) begin
      rr_ptr        <= (grant_idx == 2'd2) ? '0 : grant_idx + 2'd1;
      cur_src       <= grant_idx;
      m_axi_awid    <= {grant_idx, s_axi_awid[grant_idx*S_ID_WIDTH +: S_ID_WIDTH]};
      m_axi_awaddr  <= s_axi_awaddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      m_axi_awlen   <= s_axi_awlen[grant_idx*8 +: 8];
      m_axi_awsize  <= s_axi_awsize[grant_idx*3 +: 3];
      m_axi_awburst <= s_axi_awburst[grant_idx*2 +: 2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= '0;
    end else begin
      case ({aw_hs, b_hs})
        2'b10:   if (credits < MAX_CRED) credits <= credits + 1'b1;
        2'b01:   if (credits != '0) credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  always_comb begin
    m_axi_wdata  = s_axi_wdata[cur_src*DATA_WIDTH +: DATA_WIDTH];
    m_axi_wstrb  = s_axi_wstrb[cur_src*STRB_WIDTH +: STRB_WIDTH];
    m_axi_wlast  = s_axi_wlast[cur_src];
    m_axi_wvalid = (state == ST_WDATA) && s_axi_wvalid[cur_src];
    s_axi_wready = '0;
    if (state == ST_WDATA) s_axi_wready[cur_src] = m_axi_wready;
  end

  assign b_dst = m_axi_bid[M_ID_WIDTH-1 -: SRC_W];

  // ID and response are broadcast; only the routed source sees bvalid.
  always_comb begin
    s_axi_bvalid = '0;
    m_axi_bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_axi_bid[i*S_ID_WIDTH +: S_ID_WIDTH] = m_axi_bid[S_ID_WIDTH-1:0];
      s_axi_bresp[i*2 +: 2]                 = m_axi_bresp;
    end
    if (!rst) begin
      if (b_dst == SRC_INVALID) begin
        m_axi_bready = 1'b1;
      end else begin
        s_axi_bvalid[b_dst] = m_axi_bvalid;
        m_axi_bready        = s_axi_bready[b_dst];
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter_3x1.sv
// tb/tb_axi_wr_arbiter_3x1.sv - directed scoreboard bench for axi_wr_arbiter_3x1
module tb_axi_wr_arbiter_3x1;
  import npu_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] s_axi_awid;
  logic [95:0] s_axi_awaddr;
  logic [23:0] s_axi_awlen;
  logic [8:0]  s_axi_awsize;
  logic [5:0]  s_axi_awburst;
  logic [2:0]  s_axi_awvalid;
  logic [2:0]  s_axi_awready;
  logic [95:0] s_axi_wdata;
  logic [11:0] s_axi_wstrb;
  logic [2:0]  s_axi_wlast;
  logic [2:0]  s_axi_wvalid;
  logic [2:0]  s_axi_wready;
  logic [23:0] s_axi_bid;
  logic [5:0]  s_axi_bresp;
  logic [2:0]  s_axi_bvalid;
  logic [2:0]  s_axi_bready;
  logic [9:0]  m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [9:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;

  int n_vec  = 0;
  int n_miss = 0;

  logic [54:0] aw_q[$];
  logic [32:0] w_q[$];
  logic [9:0]  bq[$];

  axi_wr_arbiter_3x1 dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop expected AW/W on every master-side handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axi_awvalid && m_axi_awready) begin
        chk("aw_q_nonempty", 64'(aw_q.size() != 0), 64'd1);
        if (aw_q.size() != 0)
          chk("m_aw_fields", {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst},
              aw_q.pop_front());
      end
      if (m_axi_wvalid && m_axi_wready) begin
        chk("w_q_nonempty", 64'(w_q.size() != 0), 64'd1);
        if (w_q.size() != 0) chk("m_w_beat", {m_axi_wlast, m_axi_wdata}, w_q.pop_front());
      end
    end
  end

  task automatic clear_inputs();
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awvalid = '0; s_axi_wdata = '0; s_axi_wstrb = '1;
    s_axi_wlast = '0; s_axi_wvalid = '0; s_axi_bready = '0;
    m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_inputs();
    aw_q.delete(); w_q.delete(); bq.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_aw(input int src, input logic [7:0] id, input logic [31:0] addr,
                        input logic [7:0] len);
    s_axi_awid[src*8 +: 8]     = id;
    s_axi_awaddr[src*32 +: 32] = addr;
    s_axi_awlen[src*8 +: 8]    = len;
    s_axi_awsize[src*3 +: 3]   = 3'd2;
    s_axi_awburst[src*2 +: 2]  = 2'd1;
  endtask

  task automatic aw_phase(input int src, input logic [7:0] id, input logic [31:0] addr,
                          input logic [7:0] len);
    int n;
    aw_q.push_back({2'(src), id, addr, len, 3'd2, 2'd1});
    set_aw(src, id, addr, len);
    s_axi_awvalid[src] = 1'b1;
    #1;
    n = 0;
    while (!s_axi_awready[src] && n < 50) begin @(posedge clk); #2; n++; end
    chk("aw_grant_wait", 64'(n < 50), 64'd1);
    @(posedge clk); #1;
    s_axi_awvalid[src] = 1'b0;
  endtask

  task automatic w_phase(input int src, input logic [31:0] base, input logic [7:0] len);
    int n;
    for (int b = 0; b <= int'(len); b++) begin
      w_q.push_back({(b == int'(len)), base + 32'(b)});
      s_axi_wdata[src*32 +: 32] = base + 32'(b);
      s_axi_wlast[src]          = (b == int'(len));
      s_axi_wvalid[src]         = 1'b1;
      #1;
      n = 0;
      while (!s_axi_wready[src] && n < 50) begin @(posedge clk); #2; n++; end
      chk("w_ready_wait", 64'(n < 50), 64'd1);
      @(posedge clk); #1;
    end
    s_axi_wvalid[src] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ngrant;
    bit b_hs;
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;

    // Reset state
    reset_dut();
    #1;
    chk("rst_state", 64'(dut.state), 64'(ST_IDLE));
    chk("rst_credits", 64'(dut.credits), 64'd0);
    chk("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    chk("rst_m_awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("rst_m_wvalid", 64'(m_axi_wvalid), 64'd0);
    chk("rst_s_awready", 64'(s_axi_awready), 64'd0);
    chk("rst_s_wready", 64'(s_axi_wready), 64'd0);
    chk("rst_s_bvalid", 64'(s_axi_bvalid), 64'd0);
    chk("rst_m_bready", 64'(m_axi_bready), 64'd0);
    chk("rst_m_awaddr", 64'(m_axi_awaddr), 64'd0);

    // Single source 1, 4-beat burst, with early W from source 0 held off
    aw_q.push_back({10'h15A, 32'h0000_1000, 8'd3, 3'd2, 2'd1});
    for (int b = 0; b < 4; b++) w_q.push_back({(b == 3), 32'hA100_0000 + 32'(b)});
    set_aw(1, 8'h5A, 32'h0000_1000, 8'd3);
    s_axi_awvalid       = 3'b010;
    s_axi_wdata[63:32]  = 32'hA100_0000;
    s_axi_wdata[31:0]   = 32'hDEAD_0000;
    s_axi_wvalid        = 3'b011;
    #1;
    chk("t1_awready_grant", 64'(s_axi_awready), 64'b010);
    chk("t1_m_awvalid_N", 64'(m_axi_awvalid), 64'd0);
    @(posedge clk); #1 s_axi_awvalid = '0;
    #1;
    chk("t1_m_awvalid_N1", 64'(m_axi_awvalid), 64'd1);
    chk("t1_m_awid", 64'(m_axi_awid), 64'h15A);
    chk("t1_wready_in_aw", 64'(s_axi_wready), 64'd0);
    @(posedge clk); #2;
    chk("t1_m_wvalid_N2", 64'(m_axi_wvalid), 64'd1);
    chk("t1_wready_only_src1", 64'(s_axi_wready), 64'b010);
    chk("t1_credits_1", 64'(dut.credits), 64'd1);
    for (int b = 1; b < 4; b++) begin
      @(posedge clk); #1;
      s_axi_wdata[63:32] = 32'hA100_0000 + 32'(b);
      s_axi_wlast[1]     = (b == 3);
      #1 chk("t1_wready_beat", 64'(s_axi_wready), 64'b010);
    end
    @(posedge clk); #1 s_axi_wvalid = '0;
    #1 chk("t1_state_idle", 64'(dut.state), 64'(ST_IDLE));
    m_axi_bvalid = 1'b1; m_axi_bid = 10'h15A; m_axi_bresp = RESP_OKAY; s_axi_bready = 3'b010;
    #1;
    chk("t1_bvalid_src1", 64'(s_axi_bvalid), 64'b010);
    chk("t1_bid_src1", 64'(s_axi_bid[15:8]), 64'h5A);
    chk("t1_m_bready", 64'(m_axi_bready), 64'd1);
    @(posedge clk); #1 m_axi_bvalid = 1'b0; s_axi_bready = '0;
    #1 chk("t1_credits_0", 64'(dut.credits), 64'd0);

    // All three request continuously from reset: order 0,1,2,0,1,2
    reset_dut();
    for (int k = 0; k < 6; k++) begin
      aw_q.push_back({2'(k % 3), 8'h10 + 8'(k % 3), 32'h100 * 32'(k % 3), 8'd0, 3'd2, 2'd1});
      w_q.push_back({1'b1, 32'hC000_0000 + 32'(k % 3)});
    end
    for (int s = 0; s < 3; s++) begin
      set_aw(s, 8'h10 + 8'(s), 32'h100 * 32'(s), 8'd0);
      s_axi_wdata[s*32 +: 32] = 32'hC000_0000 + 32'(s);
    end
    s_axi_wlast = 3'b111; s_axi_wvalid = 3'b111; s_axi_bready = 3'b111;
    ngrant = 0;
    for (int cyc = 0; cyc < 200 && (ngrant < 6 || aw_q.size() != 0 || w_q.size() != 0 ||
                                    bq.size() != 0); cyc++) begin
      s_axi_awvalid = (ngrant < 6) ? 3'b111 : 3'b000;
      if (bq.size() != 0) begin m_axi_bvalid = 1'b1; m_axi_bid = bq[0]; end
      else m_axi_bvalid = 1'b0;
      #1;
      if ((s_axi_awready & s_axi_awvalid) != 3'b000) ngrant++;
      if (m_axi_awvalid && m_axi_awready) bq.push_back(m_axi_awid);
      b_hs = m_axi_bvalid && m_axi_bready;
      @(posedge clk); #1;
      if (b_hs) void'(bq.pop_front());
    end
    clear_inputs();
    chk("t2_grants", 64'(ngrant), 64'd6);
    chk("t2_drained", 64'(aw_q.size() + w_q.size() + bq.size()), 64'd0);

    // Credit limit: four writes with B withheld, fifth blocked until one B
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      aw_phase(0, 8'h40 + 8'(k), 32'h2000 + 32'(k*16), 8'd0);
      w_phase(0, 32'hB000_0000 + 32'(k << 8), 8'd0);
    end
    chk("t3_credits_full", 64'(dut.credits), 64'd4);
    set_aw(0, 8'h44, 32'h2040, 8'd0);
    s_axi_awvalid[0] = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_blocked", 64'(s_axi_awready), 64'd0);
      @(posedge clk); #2;
    end
    m_axi_bvalid = 1'b1; m_axi_bid = 10'h040; s_axi_bready = 3'b001;
    #1;
    chk("t3_bvalid_src0", 64'(s_axi_bvalid), 64'b001);
    chk("t3_still_blocked", 64'(s_axi_awready), 64'd0);
    @(posedge clk); #1 m_axi_bvalid = 1'b0; s_axi_bready = '0;
    #1;
    chk("t3_regrant_next", 64'(s_axi_awready), 64'b001);
    chk("t3_credits_3", 64'(dut.credits), 64'd3);
    aw_phase(0, 8'h44, 32'h2040, 8'd0);
    w_phase(0, 32'hB000_0400, 8'd0);
    chk("t3_credits_refill", 64'(dut.credits), 64'd4);

    // Simultaneous m_aw and m_b handshakes at credits=2
    for (int k = 0; k < 2; k++) begin
      m_axi_bvalid = 1'b1; m_axi_bid = 10'h041; s_axi_bready = 3'b001;
      @(posedge clk); #1 m_axi_bvalid = 1'b0; s_axi_bready = '0;
    end
    #1 chk("t4_credits_2", 64'(dut.credits), 64'd2);
    aw_q.push_back({2'd0, 8'h50, 32'h2050, 8'd0, 3'd2, 2'd1});
    set_aw(0, 8'h50, 32'h2050, 8'd0);
    s_axi_awvalid[0] = 1'b1;
    #1 chk("t4_grant", 64'(s_axi_awready), 64'b001);
    @(posedge clk); #1 s_axi_awvalid = '0;
    m_axi_bvalid = 1'b1; m_axi_bid = 10'h042; s_axi_bready = 3'b001;
    #1;
    chk("t4_m_awvalid", 64'(m_axi_awvalid), 64'd1);
    chk("t4_m_bready", 64'(m_axi_bready), 64'd1);
    @(posedge clk); #1 m_axi_bvalid = 1'b0; s_axi_bready = '0;
    #1 chk("t4_credits_hold", 64'(dut.credits), 64'd2);
    w_phase(0, 32'hB500_0000, 8'd0);

    // Invalid source tag: sunk, no bvalid, credit still returned
    m_axi_bvalid = 1'b1; m_axi_bid = 10'h3A5; m_axi_bresp = RESP_SLVERR; s_axi_bready = '0;
    #1;
    chk("t5_m_bready", 64'(m_axi_bready), 64'd1);
    chk("t5_no_bvalid", 64'(s_axi_bvalid), 64'd0);
    @(posedge clk); #1 m_axi_bvalid = 1'b0;
    #1 chk("t5_credits_dec", 64'(dut.credits), 64'd1);

    // Reset during beat 2 of an 8-beat burst
    aw_phase(2, 8'h77, 32'h3000, 8'd7);
    for (int b = 0; b < 2; b++) begin
      w_q.push_back({1'b0, 32'hE000_0000 + 32'(b)});
      s_axi_wdata[95:64] = 32'hE000_0000 + 32'(b);
      s_axi_wlast[2] = 1'b0; s_axi_wvalid[2] = 1'b1;
      #1;
      for (int n = 0; n < 50 && !s_axi_wready[2]; n++) begin @(posedge clk); #2; end
      chk("t6_wready", 64'(s_axi_wready), 64'b100);
      @(posedge clk); #1;
    end
    s_axi_wdata[95:64] = 32'hE000_0002;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    clear_inputs();
    w_q.delete();
    #1;
    chk("t6_state", 64'(dut.state), 64'(ST_IDLE));
    chk("t6_credits", 64'(dut.credits), 64'd0);
    chk("t6_m_awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("t6_m_wvalid", 64'(m_axi_wvalid), 64'd0);
    chk("t6_s_awready", 64'(s_axi_awready), 64'd0);
    chk("t6_s_wready", 64'(s_axi_wready), 64'd0);
    chk("t6_s_bvalid", 64'(s_axi_bvalid), 64'd0);
    chk("t6_m_bready", 64'(m_axi_bready), 64'd0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
